// File: rtl/calckit_pkg.sv
// -----------------------------------------------------------------------------
// calckit_pkg
// Shared definitions for the calculator datapath: matrix geometry limits,
// ASCII constants used by the text printer, the printer state encoding (also
// read by the top-level menu FSM for debug display) and small BCD helpers.
//
// Configuration macro: PRINT_DIMS_EN adds the ST_HDR state to the encoding.
// -----------------------------------------------------------------------------
package calckit_pkg;

  localparam int MAX_DIM    = 5;   // largest legal row/column count
  localparam int SLOT_WORDS = 32;  // words per physical matrix slot
  localparam int BCD_DIGITS = 5;   // enough for magnitudes up to 32768

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_MEM,
    ST_CONVERT,
    ST_EMIT_SIGN,
    ST_EMIT_DIG,
    ST_EMIT_SEP,
    ST_EMIT_CR,
    ST_EMIT_LF,
    ST_FINISH
`ifdef PRINT_DIMS_EN
    , ST_HDR
`endif
  } printer_state_e;

  // Digit at position pos, where position 0 is the most significant digit.
  function automatic logic [3:0] bcd_digit(input logic [4*BCD_DIGITS-1:0] bcd,
                                           input logic [2:0]              pos);
    bcd_digit = bcd[4*(BCD_DIGITS-1-int'(pos)) +: 4];
  endfunction

  // Position of the most significant non-zero digit; the units position when
  // the whole value is zero, so that zero still prints as a single '0'.
  function automatic logic [2:0] first_sig_digit(input logic [4*BCD_DIGITS-1:0] bcd);
    first_sig_digit = 3'(BCD_DIGITS-1);
    for (int i = BCD_DIGITS-2; i >= 0; i--) begin
      if (bcd_digit(bcd, 3'(i)) != 4'd0) first_sig_digit = 3'(i);
    end
  endfunction

endpackage

// File: rtl/matrix_uart_printer_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double dabble) binary to BCD converter.
// One load cycle followed by DATA_W shift cycles; done_o pulses during the
// final shift cycle and bcd_o holds the result from the next cycle until the
// next start.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     load request, honoured only while not busy
//   bin_i       unsigned binary input, DATA_W bits
//   busy_o      conversion in progress
//   done_o      high in the last shift cycle
//   bcd_o       BCD_DIGITS x 4-bit result, most significant digit highest
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import calckit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       sh_q,   sh_d;
  logic [4*BCD_DIGITS-1:0] bcd_q,  bcd_d;
  logic [CNT_W-1:0]        cnt_q,  cnt_d;
  logic                    busy_q, busy_d;
  logic [4*BCD_DIGITS-1:0] adj;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    adj    = bcd_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    // Digits of 5 or more would overflow past 9 when doubled; add 3 first.
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    if (!busy_q) begin
      if (start_i) begin
        sh_d   = bin_i;
        bcd_d  = '0;
        cnt_d  = CNT_W'(DATA_W);
        busy_d = 1'b1;
      end
    end else begin
      {bcd_d, sh_d} = {adj, sh_q} << 1;
      cnt_d         = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/matrix_uart_printer.sv
// -----------------------------------------------------------------------------
// matrix_uart_printer
// Reads one stored matrix from the matrix memory and streams it to the UART
// transmitter as ASCII: signed decimal elements, leading zeros suppressed,
// single spaces between elements, CR LF after each row, no trailing space.
//
// Ports:
//   sys_clk_in, sys_rst_n   clock, asynchronous active-low reset
//   start                   one-cycle print request (sampled in IDLE only)
//   slot, rows, cols        matrix location and shape, latched on start
//   busy, done, err         status; done/err are one-cycle pulses
//   mem_rd_en, mem_addr     read port towards the matrix memory
//   mem_rd_data             synchronous read data (1 cycle after mem_rd_en)
//   tx_data, tx_valid       byte towards the UART transmitter
//   tx_ready                transmitter accepts when tx_valid && tx_ready
//
// Configuration macro: PRINT_DIMS_EN emits a "<rows> <cols>\r\n" header line
// before the matrix data.
// -----------------------------------------------------------------------------
module matrix_uart_printer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int SLOT_WORDS = calckit_pkg::SLOT_WORDS,
  parameter int MAX_DIM    = calckit_pkg::MAX_DIM
) (
  input  logic              sys_clk_in,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [5:0]        slot,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  import calckit_pkg::*;

  printer_state_e state_q, state_d;
  logic [5:0]        slot_q, slot_d;
  logic [2:0]        rows_q, rows_d;
  logic [2:0]        cols_q, cols_d;
  logic [2:0]        r_q,    r_d;
  logic [2:0]        c_q,    c_d;
  logic [4:0]        idx_q,  idx_d;   // running r*cols + c
  logic [DATA_W-1:0] val_q,  val_d;
  logic [2:0]        dig_q,  dig_d;
  logic              err_q,  err_d;
`ifdef PRINT_DIMS_EN
  logic [2:0]        hdr_q,  hdr_d;
`endif

  logic                    neg;
  logic [DATA_W-1:0]       mag;
  logic                    bcd_start, bcd_busy, bcd_done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [2:0]              lead, pos;
  logic                    dims_ok, last_col, last_row;

  // Two's-complement negate; -32768 maps to 0x8000, read as unsigned 32768.
  assign neg = val_q[DATA_W-1];
  assign mag = neg ? (~val_q + DATA_W'(1)) : val_q;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk     (sys_clk_in),
    .rst_n   (sys_rst_n),
    .start_i (bcd_start),
    .bin_i   (mag),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  assign dims_ok  = (rows != 3'd0) && (cols != 3'd0) &&
                    (rows <= 3'(MAX_DIM)) && (cols <= 3'(MAX_DIM));
  assign last_col = (c_q == cols_q - 3'd1);
  assign last_row = (r_q == rows_q - 3'd1);

  // The BCD result only settles after the cycle that leaves CONVERT, so
  // leading zeros are skipped on the fly: dig_q restarts at 0 per element
  // and the emitted position is never above the first significant digit.
  assign lead = first_sig_digit(bcd);
  assign pos  = (dig_q < lead) ? lead : dig_q;

  assign mem_addr = ADDR_W'(slot_q * SLOT_WORDS) + ADDR_W'(idx_q);
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    r_d       = r_q;
    c_d       = c_q;
    idx_d     = idx_q;
    val_d     = val_q;
    dig_d     = dig_q;
    err_d     = 1'b0;
`ifdef PRINT_DIMS_EN
    hdr_d     = hdr_q;
`endif
    bcd_start = 1'b0;
    mem_rd_en = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            slot_d = slot;
            rows_d = rows;
            cols_d = cols;
            r_d    = 3'd0;
            c_d    = 3'd0;
            idx_d  = 5'd0;
`ifdef PRINT_DIMS_EN
            hdr_d   = 3'd0;
            state_d = ST_HDR;
`else
            state_d = ST_FETCH;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

`ifdef PRINT_DIMS_EN
      ST_HDR: begin
        tx_valid = 1'b1;
        case (hdr_q)
          3'd0:    tx_data = ASCII_ZERO + 8'(rows_q);
          3'd1:    tx_data = ASCII_SPACE;
          3'd2:    tx_data = ASCII_ZERO + 8'(cols_q);
          3'd3:    tx_data = ASCII_CR;
          default: tx_data = ASCII_LF;
        endcase
        if (tx_ready) begin
          if (hdr_q == 3'd4) state_d = ST_FETCH;
          else               hdr_d   = hdr_q + 3'd1;
        end
      end
`endif

      ST_FETCH: begin
        mem_rd_en = 1'b1;
        state_d   = ST_WAIT_MEM;
      end

      ST_WAIT_MEM: begin
        val_d   = mem_rd_data;
        state_d = ST_CONVERT;
      end

      ST_CONVERT: begin
        bcd_start = !bcd_busy;
        if (bcd_done) begin
          dig_d   = 3'd0;
          state_d = neg ? ST_EMIT_SIGN : ST_EMIT_DIG;
        end
      end

      ST_EMIT_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_MINUS;
        if (tx_ready) state_d = ST_EMIT_DIG;
      end

      ST_EMIT_DIG: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_ZERO + 8'(bcd_digit(bcd, pos));
        if (tx_ready) begin
          if (pos == 3'(BCD_DIGITS-1)) state_d = last_col ? ST_EMIT_CR : ST_EMIT_SEP;
          else                         dig_d   = pos + 3'd1;
        end
      end

      ST_EMIT_SEP: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_SPACE;
        if (tx_ready) begin
          c_d     = c_q + 3'd1;
          idx_d   = idx_q + 5'd1;
          state_d = ST_FETCH;
        end
      end

      ST_EMIT_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (tx_ready) state_d = ST_EMIT_LF;
      end

      ST_EMIT_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) begin
          if (last_row) begin
            state_d = ST_FINISH;
          end else begin
            r_d     = r_q + 3'd1;
            c_d     = 3'd0;
            idx_d   = idx_q + 5'd1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dig_q   <= '0;
      err_q   <= 1'b0;
`ifdef PRINT_DIMS_EN
      hdr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
`ifdef PRINT_DIMS_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// -----------------------------------------------------------------------------
// tb_matrix_uart_printer
// Scoreboard bench for matrix_uart_printer. Expected text is built from the
// stored matrix with $sformatf("%0d") and queued per byte; a monitor pops and
// compares on every accepted transmitter byte. Honours PRINT_DIMS_EN.
// -----------------------------------------------------------------------------
module tb_matrix_uart_printer;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 11;
  localparam int SLOT_WORDS = 32;
  localparam int MAX_DIM    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start;
  logic [5:0]        slot;
  logic [2:0]        rows, cols;
  logic              busy, done, err, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  always #5 clk = ~clk;

  matrix_uart_printer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SLOT_WORDS(SLOT_WORDS), .MAX_DIM(MAX_DIM)
  ) dut (
    .sys_clk_in (clk),
    .sys_rst_n  (rst_n),
    .start      (start),
    .slot       (slot),
    .rows       (rows),
    .cols       (cols),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  // Matrix memory: synchronous read
  logic signed [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int n_checks = 0, n_fail = 0;
  int n_bytes = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0;
  logic [7:0] exp_q[$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n) begin
      if (mem_rd_en) rd_cnt++;
      if (err) err_cnt++;
      if (err || done) check("err_done_exclusive", {31'd0, err && done}, 32'd0);
      if (done) begin
        done_cnt++;
        check("done_busy_low", {31'd0, busy}, 32'd0);
        check("done_stream_drained", exp_q.size(), 32'd0);
      end
      if (tx_valid && tx_ready) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, e});
        end
      end
    end
  end

  // Random transmitter backpressure
  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference model: the text a terminal should show for this matrix.
  task automatic push_expected(input int s, input int nr, input int nc);
`ifdef PRINT_DIMS_EN
    push_str($sformatf("%0d %0d", nr, nc));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        push_str($sformatf("%0d", mem[s*SLOT_WORDS + r*nc + c]));
        if (c < nc - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'($urandom_range(0, 19)) - 16'd9;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_random(input int s, input int nr, input int nc);
    for (int i = 0; i < nr*nc; i++) mem[s*SLOT_WORDS + i] = rand_val();
  endtask

  task automatic start_req(input int s, input int nr, input int nc);
    @(posedge clk); #1;
    start = 1'b1; slot = 6'(s); rows = 3'(nr); cols = 3'(nc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_matrix(input int s, input int nr, input int nc,
                            input bit lat_chk, input bit stall, input bit dup_start);
    int d0, b0, r0, cyc, changes;
    logic [7:0] d_hold;
    logic       v_hold;
    d0 = done_cnt; b0 = n_bytes; r0 = rd_cnt;
    push_expected(s, nr, nc);
    start_req(s, nr, nc);
`ifndef PRINT_DIMS_EN
    if (lat_chk) begin
      @(negedge clk);
      check("fetch_after_start", {30'd0, mem_rd_en, busy}, 32'd3);
      check("first_addr", {21'd0, mem_addr}, s*SLOT_WORDS);
      cyc = 0;
      while (!tx_valid && cyc < 100) begin @(negedge clk); cyc++; end
      check("first_byte_latency", cyc, 32'd19);
    end
`endif
    if (dup_start) begin
      repeat (3) @(posedge clk);
      start_req(0, 1, 1);
    end
    if (stall) begin
      cyc = 0;
      while (n_bytes < b0 + 3 && cyc < 2000) begin @(posedge clk); cyc++; end
      #1 tx_ready = 1'b0;
      @(negedge clk);
      d_hold = tx_data; v_hold = tx_valid;
      check("stall_valid", {31'd0, v_hold}, 32'd1);
      changes = 0;
      repeat (50) begin
        @(negedge clk);
        if (tx_data !== d_hold || tx_valid !== v_hold) changes++;
      end
      check("stall_frozen", changes, 32'd0);
      @(posedge clk); #1 tx_ready = 1'b1;
    end
    cyc = 0;
    while (done_cnt < d0 + 1 && cyc < 6000) begin @(posedge clk); cyc++; end
    @(posedge clk);
    check("done_count", done_cnt - d0, 32'd1);
    check("stream_drained", exp_q.size(), 32'd0);
    check("read_count", rd_cnt - r0, nr*nc);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic illegal_start(input int nr, input int nc);
    int e0, r0, b0;
    bit act;
    e0 = err_cnt; r0 = rd_cnt; b0 = n_bytes; act = 1'b0;
    start_req(0, nr, nc);
    repeat (20) begin
      @(negedge clk);
      if (busy || tx_valid || mem_rd_en) act = 1'b1;
    end
    check($sformatf("err_pulse_%0dx%0d", nr, nc), err_cnt - e0, 32'd1);
    check($sformatf("no_activity_%0dx%0d", nr, nc), {31'd0, act}, 32'd0);
    check($sformatf("no_reads_bytes_%0dx%0d", nr, nc), (rd_cnt - r0) + (n_bytes - b0), 32'd0);
  endtask

  initial begin
    int b0, cyc, s, nr, nc;
    start = 1'b0; slot = '0; rows = '0; cols = '0; tx_ready = 1'b1;
    foreach (mem[i]) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {8'd0, busy, done, err, mem_rd_en, tx_valid, mem_addr, tx_data}, 32'd0);
    rst_n = 1'b1;

    // 2x3 in slot 14 with latency and backpressure checks
    for (int i = 0; i < 6; i++) mem[14*SLOT_WORDS + i] = 16'(i + 1);
    run_matrix(14, 2, 3, 1'b1, 1'b1, 1'b0);

    // Sign, zero and extremes
    mem[3*SLOT_WORDS + 0] = -16'sd5;
    mem[3*SLOT_WORDS + 1] = 16'sd0;
    mem[3*SLOT_WORDS + 2] = 16'sd32767;
    run_matrix(3, 1, 3, 1'b0, 1'b0, 1'b0);
    mem[63*SLOT_WORDS] = 16'h8000;
    run_matrix(63, 1, 1, 1'b0, 1'b0, 1'b0);

    // 2x2 all sevens
    for (int i = 0; i < 4; i++) mem[1*SLOT_WORDS + i] = 16'sd7;
    run_matrix(1, 2, 2, 1'b0, 1'b0, 1'b0);

    // Illegal dimensions
    illegal_start(0, 3);
    illegal_start(2, 6);
    illegal_start(7, 1);

    // Second start while busy must be ignored
    fill_random(5, 2, 2);
    run_matrix(5, 2, 2, 1'b0, 1'b0, 1'b1);

    // Largest legal matrix under random backpressure
    fill_random(20, MAX_DIM, MAX_DIM);
    rand_ready = 1'b1;
    run_matrix(20, MAX_DIM, MAX_DIM, 1'b0, 1'b0, 1'b0);
    rand_ready = 1'b0; #1 tx_ready = 1'b1;

    // Reset in the middle of a row, then a complete reprint
    fill_random(9, 3, 4);
    b0 = n_bytes;
    push_expected(9, 3, 4);
    start_req(9, 3, 4);
    cyc = 0;
    while (n_bytes < b0 + 5 && cyc < 2000) begin @(posedge clk); cyc++; end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {8'd0, busy, done, err, mem_rd_en, tx_valid, mem_addr, tx_data}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_matrix(9, 3, 4, 1'b1, 1'b0, 1'b0);

    // Random matrices under random backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      s  = $urandom_range(0, 63);
      nr = $urandom_range(1, MAX_DIM);
      nc = $urandom_range(1, MAX_DIM);
      fill_random(s, nr, nc);
      run_matrix(s, nr, nc, 1'b0, 1'b0, 1'b0);
    end
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
